// File: rtl/fir_pkg.sv
// Shared FIR types: default widths, accumulator FSM states and signed data typedefs.
package fir_pkg;

    localparam int PROD_W_DEF = 32;
    localparam int OUT_W_DEF  = 16;

    typedef enum logic [1:0] {IDLE, ACC, OUT} akum_state_t;

    typedef logic signed [PROD_W_DEF-1:0] prod_t;
    typedef logic signed [OUT_W_DEF-1:0]  sample_t;

endpackage

// File: rtl/akumulator_fir_if.sv
// Handshake bundle between the multiplier, the accumulator and the downstream sample consumer.
interface akumulator_fir_if #(
    parameter int PROD_W = 32,
    parameter int OUT_W  = 16,
    parameter int TAPS   = 16
);
    localparam int IDX_W = (TAPS > 1) ? $clog2(TAPS) : 1;

    logic                     start;
    logic signed [PROD_W-1:0] mnozenie_wynik;
    logic                     mnozenie_valid;
    logic [IDX_W-1:0]         tap_idx;
    logic                     busy;
    logic signed [OUT_W-1:0]  wynik;
    logic                     wynik_valid;
    logic                     wynik_ready;
    logic                     nasyc;

    modport master (
        output start, mnozenie_wynik, mnozenie_valid, wynik_ready,
        input  tap_idx, busy, wynik, wynik_valid, nasyc
    );

    modport slave (
        input  start, mnozenie_wynik, mnozenie_valid, wynik_ready,
        output tap_idx, busy, wynik, wynik_valid, nasyc
    );

endinterface

// File: rtl/akumulator_fir_zaokr_nasyc.sv
// Combinational round-half-up and saturate from the wide accumulator down to a Q15 sample.
module zaokr_nasyc #(
    parameter int ACC_W = 36,
    parameter int OUT_W = 16,
    parameter int SHIFT = 15
) (
    input  logic signed [ACC_W-1:0] i_acc,
    output logic signed [OUT_W-1:0] o_wynik,
    output logic                    o_nasyc
);
    // One extra bit so adding the rounding constant can never wrap.
    localparam int SUM_W = ACC_W + 1;

    localparam logic signed [SUM_W-1:0] HALF = {{(SUM_W-1){1'b0}}, 1'b1} << (SHIFT-1);
    localparam logic signed [SUM_W-1:0] MAXV = {{(SUM_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [SUM_W-1:0] MINV = {{(SUM_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    logic signed [SUM_W-1:0] w_sum;
    logic signed [SUM_W-1:0] w_shr;

    assign w_sum = {i_acc[ACC_W-1], i_acc} + HALF;
    assign w_shr = w_sum >>> SHIFT;

    always_comb begin
        o_wynik = w_shr[OUT_W-1:0];
        o_nasyc = 1'b0;
        if (w_shr > MAXV) begin
            o_wynik = {1'b0, {(OUT_W-1){1'b1}}};
            o_nasyc = 1'b1;
        end else if (w_shr < MINV) begin
            o_wynik = {1'b1, {(OUT_W-1){1'b0}}};
            o_nasyc = 1'b1;
        end
    end

endmodule

// File: rtl/akumulator_fir.sv
// Sums TAPS signed products per output sample, then rounds/saturates to Q15 behind a valid/ready handshake.
module akumulator_fir
    import fir_pkg::*;
#(
    parameter int PROD_W = PROD_W_DEF,
    parameter int TAPS   = 16,
    parameter int ACC_W  = PROD_W + $clog2(TAPS),
    parameter int OUT_W  = OUT_W_DEF,
    parameter int SHIFT  = 15
) (
    input  logic            clk,
    input  logic            rst,
    akumulator_fir_if.slave bus
);
    localparam int IDX_W = (TAPS > 1) ? $clog2(TAPS) : 1;

    akum_state_t             r_state;
    logic signed [ACC_W-1:0] r_acc;
    logic [IDX_W-1:0]        r_tap;
    logic signed [OUT_W-1:0] r_wynik;
    logic                    r_nasyc;

    logic signed [ACC_W-1:0] w_acc_next;
    logic signed [OUT_W-1:0] w_round;
    logic                    w_sat;
    logic                    w_last;

    assign w_acc_next = r_acc + {{(ACC_W-PROD_W){bus.mnozenie_wynik[PROD_W-1]}}, bus.mnozenie_wynik};
    assign w_last     = (r_tap == IDX_W'(TAPS-1));

    // Rounding works on the sum including the product arriving this cycle, so the
    // final tap lands in wynik on the same edge that leaves ACC.
    zaokr_nasyc #(
        .ACC_W (ACC_W),
        .OUT_W (OUT_W),
        .SHIFT (SHIFT)
    ) u_zaokr (
        .i_acc   (w_acc_next),
        .o_wynik (w_round),
        .o_nasyc (w_sat)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_acc   <= '0;
            r_tap   <= '0;
            r_wynik <= '0;
            r_nasyc <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_acc   <= '0;
                        r_tap   <= '0;
                        r_state <= ACC;
                    end
                end
                ACC: begin
                    if (bus.mnozenie_valid) begin
                        r_acc <= w_acc_next;
                        if (w_last) begin
                            r_tap   <= '0;
                            r_wynik <= w_round;
                            r_nasyc <= w_sat;
                            r_state <= OUT;
                        end else begin
                            r_tap <= r_tap + IDX_W'(1);
                        end
                    end
                end
                OUT: begin
                    if (bus.wynik_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.tap_idx     = r_tap;
    assign bus.busy        = (r_state != IDLE);
    assign bus.wynik       = r_wynik;
    assign bus.wynik_valid = (r_state == OUT);
    assign bus.nasyc       = r_nasyc;

endmodule

// File: tb/tb_akumulator_fir.sv
// Directed self-checking bench for akumulator_fir: a TAPS=4 instance and a TAPS=16 instance.
module tb_akumulator_fir;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    akumulator_fir_if #(.PROD_W(32), .OUT_W(16), .TAPS(4))  bus4 ();
    akumulator_fir_if #(.PROD_W(32), .OUT_W(16), .TAPS(16)) bus16 ();

    akumulator_fir #(.PROD_W(32), .TAPS(4), .OUT_W(16), .SHIFT(15)) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4)
    );

    akumulator_fir #(.PROD_W(32), .TAPS(16), .OUT_W(16), .SHIFT(15)) dut16 (
        .clk (clk),
        .rst (rst),
        .bus (bus16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives one full TAPS=4 sample back-to-back and accepts it immediately.
    task automatic run4(input logic signed [31:0] p0, input logic signed [31:0] p1,
                        input logic signed [31:0] p2, input logic signed [31:0] p3,
                        output logic signed [15:0] w, output logic n, output logic v);
        logic signed [31:0] p [4];
        p = '{p0, p1, p2, p3};
        @(negedge clk); bus4.start = 1'b1;
        @(negedge clk); bus4.start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus4.mnozenie_valid = 1'b1;
            bus4.mnozenie_wynik = p[i];
            @(negedge clk);
        end
        bus4.mnozenie_valid = 1'b0;
        v = bus4.wynik_valid;
        w = bus4.wynik;
        n = bus4.nasyc;
        bus4.wynik_ready = 1'b1;
        @(negedge clk);
        bus4.wynik_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        total += 5;
        if (bus4.busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy: got %b expected 0", bus4.busy); end
        if (bus4.wynik_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid: got %b expected 0", bus4.wynik_valid); end
        if (bus4.tap_idx !== 2'd0) begin bad++; $display("[TB] FAIL reset_tap: got %0d expected 0", bus4.tap_idx); end
        if (bus4.wynik !== 16'sd0) begin bad++; $display("[TB] FAIL reset_wynik: got %0d expected 0", bus4.wynik); end
        if (bus4.nasyc !== 1'b0) begin bad++; $display("[TB] FAIL reset_nasyc: got %b expected 0", bus4.nasyc); end
        total++;
        if (bus16.busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy16: got %b expected 0", bus16.busy); end
    endtask

    task automatic test_basic;
        @(negedge clk); bus4.start = 1'b1;
        @(negedge clk); bus4.start = 1'b0;
        total++;
        if (bus4.busy !== 1'b1) begin bad++; $display("[TB] FAIL basic_busy: got %b expected 1", bus4.busy); end
        for (int i = 0; i < 4; i++) begin
            bus4.mnozenie_valid = 1'b1;
            bus4.mnozenie_wynik = 32'sd16384;
            total += 2;
            if (bus4.tap_idx !== 2'(i)) begin bad++; $display("[TB] FAIL basic_tap%0d: got %0d expected %0d", i, bus4.tap_idx, i); end
            if (bus4.wynik_valid !== 1'b0) begin bad++; $display("[TB] FAIL basic_early_valid%0d: got %b expected 0", i, bus4.wynik_valid); end
            @(negedge clk);
        end
        bus4.mnozenie_valid = 1'b0;
        total += 4;
        if (bus4.wynik_valid !== 1'b1) begin bad++; $display("[TB] FAIL basic_latency: got valid=%b expected 1", bus4.wynik_valid); end
        if (bus4.wynik !== 16'sd2) begin bad++; $display("[TB] FAIL basic_wynik: got %0d expected 2", bus4.wynik); end
        if (bus4.nasyc !== 1'b0) begin bad++; $display("[TB] FAIL basic_nasyc: got %b expected 0", bus4.nasyc); end
        if (bus4.tap_idx !== 2'd0) begin bad++; $display("[TB] FAIL basic_tap_wrap: got %0d expected 0", bus4.tap_idx); end
        bus4.wynik_ready = 1'b1;
        @(negedge clk);
        bus4.wynik_ready = 1'b0;
        total += 2;
        if (bus4.wynik_valid !== 1'b0) begin bad++; $display("[TB] FAIL basic_accept_valid: got %b expected 0", bus4.wynik_valid); end
        if (bus4.busy !== 1'b0) begin bad++; $display("[TB] FAIL basic_accept_busy: got %b expected 0", bus4.busy); end
    endtask

    task automatic test_saturation;
        logic signed [15:0] w;
        logic n, v;
        run4(32'h4000_0000, 32'h4000_0000, 32'h4000_0000, 32'h4000_0000, w, n, v);
        total += 3;
        if (v !== 1'b1) begin bad++; $display("[TB] FAIL satpos_valid: got %b expected 1", v); end
        if (w !== 16'sd32767) begin bad++; $display("[TB] FAIL satpos_wynik: got %0d expected 32767", w); end
        if (n !== 1'b1) begin bad++; $display("[TB] FAIL satpos_nasyc: got %b expected 1", n); end
        run4(32'hC000_0000, 32'hC000_0000, 32'hC000_0000, 32'hC000_0000, w, n, v);
        total += 3;
        if (v !== 1'b1) begin bad++; $display("[TB] FAIL satneg_valid: got %b expected 1", v); end
        if (w !== -16'sd32768) begin bad++; $display("[TB] FAIL satneg_wynik: got %0d expected -32768", w); end
        if (n !== 1'b1) begin bad++; $display("[TB] FAIL satneg_nasyc: got %b expected 1", n); end
    endtask

    task automatic test_rounding;
        logic signed [31:0] vin [4];
        logic signed [15:0] vexp [4];
        logic signed [15:0] w;
        logic n, v;
        vin  = '{32'sd16384, 32'sd16383, -32'sd16384, -32'sd16385};
        vexp = '{16'sd1, 16'sd0, 16'sd0, -16'sd1};
        for (int k = 0; k < 4; k++) begin
            run4(vin[k], 32'sd0, 32'sd0, 32'sd0, w, n, v);
            total += 3;
            if (v !== 1'b1) begin bad++; $display("[TB] FAIL round%0d_valid: got %b expected 1", k, v); end
            if (w !== vexp[k]) begin bad++; $display("[TB] FAIL round%0d_wynik: got %0d expected %0d", k, w, vexp[k]); end
            if (n !== 1'b0) begin bad++; $display("[TB] FAIL round%0d_nasyc: got %b expected 0", k, n); end
        end
    endtask

    task automatic test_gaps_backpressure;
        logic pattern [7];
        logic [1:0] tap_exp [7];
        pattern = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        tap_exp = '{2'd1, 2'd1, 2'd1, 2'd2, 2'd3, 2'd3, 2'd0};
        @(negedge clk); bus4.start = 1'b1;
        @(negedge clk); bus4.start = 1'b0;
        for (int i = 0; i < 7; i++) begin
            bus4.mnozenie_valid = pattern[i];
            bus4.mnozenie_wynik = pattern[i] ? 32'sd32768 : 32'sh7FFF_FFFF;
            @(negedge clk);
            total++;
            if (bus4.tap_idx !== tap_exp[i]) begin bad++; $display("[TB] FAIL gap_tap%0d: got %0d expected %0d", i, bus4.tap_idx, tap_exp[i]); end
        end
        total += 2;
        if (bus4.wynik_valid !== 1'b1) begin bad++; $display("[TB] FAIL gap_valid: got %b expected 1", bus4.wynik_valid); end
        if (bus4.wynik !== 16'sd4) begin bad++; $display("[TB] FAIL gap_wynik: got %0d expected 4", bus4.wynik); end
        // Hammer start and products while downstream stalls; nothing may move.
        bus4.start = 1'b1;
        bus4.mnozenie_valid = 1'b1;
        bus4.mnozenie_wynik = 32'h4000_0000;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            total += 4;
            if (bus4.wynik_valid !== 1'b1) begin bad++; $display("[TB] FAIL stall%0d_valid: got %b expected 1", c, bus4.wynik_valid); end
            if (bus4.wynik !== 16'sd4) begin bad++; $display("[TB] FAIL stall%0d_wynik: got %0d expected 4", c, bus4.wynik); end
            if (bus4.nasyc !== 1'b0) begin bad++; $display("[TB] FAIL stall%0d_nasyc: got %b expected 0", c, bus4.nasyc); end
            if (bus4.tap_idx !== 2'd0) begin bad++; $display("[TB] FAIL stall%0d_tap: got %0d expected 0", c, bus4.tap_idx); end
        end
        bus4.wynik_ready = 1'b1;
        @(negedge clk);
        bus4.wynik_ready = 1'b0;
        bus4.start = 1'b0;
        bus4.mnozenie_valid = 1'b0;
        total += 3;
        if (bus4.busy !== 1'b0) begin bad++; $display("[TB] FAIL stall_accept_busy: got %b expected 0", bus4.busy); end
        if (bus4.wynik_valid !== 1'b0) begin bad++; $display("[TB] FAIL stall_accept_valid: got %b expected 0", bus4.wynik_valid); end
        if (bus4.tap_idx !== 2'd0) begin bad++; $display("[TB] FAIL stall_accept_tap: got %0d expected 0", bus4.tap_idx); end
    endtask

    task automatic test_reset_mid;
        logic signed [15:0] w;
        logic n, v;
        @(negedge clk); bus4.start = 1'b1;
        @(negedge clk); bus4.start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bus4.mnozenie_valid = 1'b1;
            bus4.mnozenie_wynik = 32'sd1000000;
            @(negedge clk);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus4.mnozenie_valid = 1'b0;
        total += 3;
        if (bus4.busy !== 1'b0) begin bad++; $display("[TB] FAIL midrst_busy: got %b expected 0", bus4.busy); end
        if (bus4.tap_idx !== 2'd0) begin bad++; $display("[TB] FAIL midrst_tap: got %0d expected 0", bus4.tap_idx); end
        if (bus4.wynik_valid !== 1'b0) begin bad++; $display("[TB] FAIL midrst_valid: got %b expected 0", bus4.wynik_valid); end
        run4(32'sd16384, 32'sd16384, 32'sd16384, 32'sd16384, w, n, v);
        total += 3;
        if (v !== 1'b1) begin bad++; $display("[TB] FAIL midrst_rerun_valid: got %b expected 1", v); end
        if (w !== 16'sd2) begin bad++; $display("[TB] FAIL midrst_rerun_wynik: got %0d expected 2", w); end
        if (n !== 1'b0) begin bad++; $display("[TB] FAIL midrst_rerun_nasyc: got %b expected 0", n); end
    endtask

    task automatic test_taps16_start_valid;
        // A product presented alongside start must not be counted.
        @(negedge clk);
        bus16.start = 1'b1;
        bus16.mnozenie_valid = 1'b1;
        bus16.mnozenie_wynik = 32'h4000_0000;
        @(negedge clk);
        bus16.start = 1'b0;
        total++;
        if (bus16.tap_idx !== 4'd0) begin bad++; $display("[TB] FAIL t16_start_tap: got %0d expected 0", bus16.tap_idx); end
        for (int i = 0; i < 16; i++) begin
            bus16.mnozenie_valid = 1'b1;
            bus16.mnozenie_wynik = 32'sd2048;
            if (i == 15) begin
                total++;
                if (bus16.tap_idx !== 4'd15) begin bad++; $display("[TB] FAIL t16_last_tap: got %0d expected 15", bus16.tap_idx); end
            end
            @(negedge clk);
        end
        bus16.mnozenie_valid = 1'b0;
        total += 3;
        if (bus16.wynik_valid !== 1'b1) begin bad++; $display("[TB] FAIL t16_valid: got %b expected 1", bus16.wynik_valid); end
        if (bus16.wynik !== 16'sd1) begin bad++; $display("[TB] FAIL t16_wynik: got %0d expected 1", bus16.wynik); end
        if (bus16.nasyc !== 1'b0) begin bad++; $display("[TB] FAIL t16_nasyc: got %b expected 0", bus16.nasyc); end
        bus16.wynik_ready = 1'b1;
        @(negedge clk);
        bus16.wynik_ready = 1'b0;
        total++;
        if (bus16.busy !== 1'b0) begin bad++; $display("[TB] FAIL t16_accept_busy: got %b expected 0", bus16.busy); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        bus4.start = 1'b0;  bus4.mnozenie_valid = 1'b0;  bus4.mnozenie_wynik = '0;  bus4.wynik_ready = 1'b0;
        bus16.start = 1'b0; bus16.mnozenie_valid = 1'b0; bus16.mnozenie_wynik = '0; bus16.wynik_ready = 1'b0;
        test_reset();
        test_basic();
        test_saturation();
        test_rounding();
        test_gaps_backpressure();
        test_reset_mid();
        test_taps16_start_valid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
